usb_link_mon: RTL

USB_LINK_MON -- requirements
Module: usb_link_mon

---
 rtl/usb_link_mon.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/usb_link_mon.sv
// USB link-state monitor: tracks bus reset, suspend, host resume and remote wakeup
// from the synchronised line levels, with microsecond timing from a clk prescaler.
module usb_link_mon #(
  parameter int unsigned CLK_MHZ       = 48,
  parameter int unsigned T_RESET_US    = 10000,
  parameter int unsigned T_SUSPEND_US  = 3000,
  parameter int unsigned T_WAKE_MIN_US = 5000,
  parameter int unsigned T_WAKE_US     = 2000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_dp,
  input  logic       rx_dn,
  input  logic       sof,
  input  logic       activity,
  input  logic       wake_req,
  output logic [2:0] state,
  output logic       usb_rst,
  output logic       suspend,
  output logic       tx_k_en,
  output logic       evt_reset,
  output logic       evt_suspend,
  output logic       evt_resume
);

  typedef enum logic [2:0] {
    StActive    = 3'd0,
    StSuspended = 3'd1,
    StWakeup    = 3'd2,
    StResume    = 3'd3,
    StBusReset  = 3'd4
  } link_state_e;

  localparam logic [7:0]  PresMax    = 8'(CLK_MHZ - 1);
  localparam logic [15:0] ResetLim   = 16'(T_RESET_US);
  localparam logic [15:0] SuspendLim = 16'(T_SUSPEND_US);
  localparam logic [15:0] WakeMinLim = 16'(T_WAKE_MIN_US);
  localparam logic [15:0] WakeLim    = 16'(T_WAKE_US);
  localparam logic [15:0] CntMax     = 16'hffff;

  link_state_e state_q, state_d;
  logic [7:0]  presc_q, presc_d;
  logic [15:0] se0_cnt_q, se0_cnt_d;
  logic [15:0] idle_cnt_q, idle_cnt_d;
  logic [15:0] tmr_q, tmr_d;
  logic        usb_rst_q, suspend_q, tx_k_en_q;
  logic        evt_reset_q, evt_suspend_q, evt_resume_q;
  logic        tick;
  logic        line_j, line_k, line_se0;

  assign line_j   = rx_dp & ~rx_dn;
  assign line_k   = ~rx_dp & rx_dn;
  assign line_se0 = ~rx_dp & ~rx_dn;

  assign tick    = (presc_q == PresMax);
  assign presc_d = tick ? 8'd0 : presc_q + 8'd1;

  // Counters saturate so that long holds never wrap back below a threshold.
  always_comb begin
    se0_cnt_d = se0_cnt_q;
    if (!line_se0) begin
      se0_cnt_d = '0;
    end else if (tick && se0_cnt_q != CntMax) begin
      se0_cnt_d = se0_cnt_q + 16'd1;
    end

    idle_cnt_d = idle_cnt_q;
    if (sof || activity || !line_j) begin
      idle_cnt_d = '0;
    end else if (tick && idle_cnt_q != CntMax) begin
      idle_cnt_d = idle_cnt_q + 16'd1;
    end

    tmr_d = tmr_q;
    if (state_d != state_q) begin
      tmr_d = '0;
    end else if (tick && tmr_q != CntMax) begin
      tmr_d = tmr_q + 16'd1;
    end
  end

  // Next-state logic; bus reset always takes priority where it applies.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StActive: begin
        if (se0_cnt_q >= ResetLim) begin
          state_d = StBusReset;
        end else if (idle_cnt_q >= SuspendLim) begin
          state_d = StSuspended;
        end
      end
      StSuspended: begin
        if (se0_cnt_q >= ResetLim) begin
          state_d = StBusReset;
        end else if (line_k) begin
          state_d = StResume;
        end else if (wake_req && tmr_q >= WakeMinLim) begin
          state_d = StWakeup;
        end
      end
      StWakeup: begin
        if (tmr_q >= WakeLim) begin
          state_d = StResume;
        end
      end
      StResume: begin
        if (line_se0) begin
          state_d = StActive;
        end
      end
      StBusReset: begin
        if (!line_se0) begin
          state_d = StActive;
        end
      end
      default: state_d = StActive;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StActive;
      presc_q       <= '0;
      se0_cnt_q     <= '0;
      idle_cnt_q    <= '0;
      tmr_q         <= '0;
      usb_rst_q     <= 1'b0;
      suspend_q     <= 1'b0;
      tx_k_en_q     <= 1'b0;
      evt_reset_q   <= 1'b0;
      evt_suspend_q <= 1'b0;
      evt_resume_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      presc_q       <= presc_d;
      se0_cnt_q     <= se0_cnt_d;
      idle_cnt_q    <= idle_cnt_d;
      tmr_q         <= tmr_d;
      // Flags are registered from state_d so they line up with the state output.
      usb_rst_q     <= (state_d == StBusReset);
      suspend_q     <= (state_d == StSuspended) || (state_d == StWakeup);
      tx_k_en_q     <= (state_d == StWakeup);
      evt_reset_q   <= (state_d == StBusReset) && (state_q != StBusReset);
      evt_suspend_q <= (state_d == StSuspended) && (state_q != StSuspended);
      evt_resume_q  <= (state_q == StResume) && (state_d == StActive);
    end
  end

  assign state       = state_q;
  assign usb_rst     = usb_rst_q;
  assign suspend     = suspend_q;
  assign tx_k_en     = tx_k_en_q;
  assign evt_reset   = evt_reset_q;
  assign evt_suspend = evt_suspend_q;
  assign evt_resume  = evt_resume_q;

endmodule
